// File: rtl/tx_frame_streamer_if.sv
// Slot handshake, buffer-read port and transmit stream of tx_frame_streamer.
interface tx_frame_streamer_if #(
  parameter int data_width_p = 64
);
  localparam int bytes_lp = data_width_p / 8;

  logic                    slot_v_i;
  logic                    slot_ready_and_o;
  logic [15:0]             size_i;
  logic                    rd_v_o;
  logic [10:0]             rd_addr_o;
  logic [data_width_p-1:0] rd_data_i;
  logic                    tx_v_o;
  logic                    tx_ready_and_i;
  logic [data_width_p-1:0] tx_data_o;
  logic [bytes_lp-1:0]     tx_keep_o;
  logic                    tx_last_o;

  modport master (
    input  slot_v_i, size_i, rd_data_i, tx_ready_and_i,
    output slot_ready_and_o, rd_v_o, rd_addr_o, tx_v_o, tx_data_o, tx_keep_o, tx_last_o
  );

  modport slave (
    output slot_v_i, size_i, rd_data_i, tx_ready_and_i,
    input  slot_ready_and_o, rd_v_o, rd_addr_o, tx_v_o, tx_data_o, tx_keep_o, tx_last_o
  );
endinterface

// File: rtl/tx_frame_streamer.sv
// Reads one TX slot word by word from buffer memory and streams it out as keep-masked
// beats through a 2-entry FIFO, then releases the slot.
module tx_frame_streamer #(
  parameter int data_width_p = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  tx_frame_streamer_if.master bus
);
  localparam int bytes_lp      = data_width_p / 8;
  localparam int addr_width_lp = 11;
  localparam int off_width_lp  = $clog2(bytes_lp);
  localparam int len_width_lp  = addr_width_lp + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e                   state_r, state_n_s;
  logic [addr_width_lp-1:0] addr_r;
  logic [len_width_lp-1:0]  words_left_r;
  logic [bytes_lp-1:0]      last_keep_r;
  logic                     infl_r, infl_last_r;
  logic [1:0]               count_r;
  logic                     wr_ptr_r, rd_ptr_r;
  logic [data_width_p-1:0]  data_mem_r [2];
  logic [bytes_lp-1:0]      keep_mem_r [2];
  logic [1:0]               last_mem_r;

  logic [len_width_lp-1:0]  len_s, words_s;
  logic [off_width_lp-1:0]  rem_s;
  logic [bytes_lp-1:0]      last_keep_s;
  logic [2:0]               pending_s;
  logic                     head_v_s, head_last_s, pop_s, credit_s;
  logic                     latch_s, rd_v_s, release_s;

  // Clamp the slot length and derive its word count and final-beat keep mask.
  always_comb begin
    if (bus.size_i > 16'd2048) begin
      len_s = 12'd2048;
    end else begin
      len_s = bus.size_i[len_width_lp-1:0];
    end
    words_s = (len_s + 12'(bytes_lp - 1)) >> off_width_lp;
    rem_s   = len_s[off_width_lp-1:0];
    for (int b = 0; b < bytes_lp; b++) begin
      last_keep_s[b] = (rem_s == {off_width_lp{1'b0}}) || (b < int'(rem_s));
    end
  end

  // A read may be issued when it would not overfill the FIFO once this cycle's pop leaves.
  assign head_v_s    = (count_r != 2'd0);
  assign head_last_s = last_mem_r[rd_ptr_r];
  assign pop_s       = head_v_s & bus.tx_ready_and_i;
  assign pending_s   = {1'b0, count_r} + {2'b00, infl_r} - {2'b00, pop_s};
  assign credit_s    = (pending_s < 3'd2);

  // Next-state and control decode.
  always_comb begin
    state_n_s = state_r;
    latch_s   = 1'b0;
    rd_v_s    = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.slot_v_i) begin
          latch_s   = 1'b1;
          state_n_s = (len_s != 12'd0) ? ST_STREAM : ST_RELEASE;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (credit_s) begin
          rd_v_s    = 1'b1;
          state_n_s = (words_left_r == 12'd1) ? ST_DRAIN : ST_STREAM;
        end else begin
          state_n_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_last_s) begin
          state_n_s = ST_RELEASE;
        end else begin
          state_n_s = ST_DRAIN;
        end
      end
      ST_RELEASE: begin
        release_s = 1'b1;
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, read sequencing, in-flight tracking and the output FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      addr_r       <= 11'd0;
      words_left_r <= 12'd0;
      last_keep_r  <= {bytes_lp{1'b0}};
      infl_r       <= 1'b0;
      infl_last_r  <= 1'b0;
      count_r      <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      last_mem_r   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        data_mem_r[i] <= {data_width_p{1'b0}};
        keep_mem_r[i] <= {bytes_lp{1'b0}};
      end
    end else begin
      state_r <= state_n_s;
      if (latch_s) begin
        addr_r       <= 11'd0;
        words_left_r <= words_s;
        last_keep_r  <= last_keep_s;
      end else if (rd_v_s) begin
        addr_r       <= addr_r + 11'(bytes_lp);
        words_left_r <= words_left_r - 12'd1;
      end
      infl_r      <= rd_v_s;
      infl_last_r <= rd_v_s && (words_left_r == 12'd1);
      if (infl_r) begin
        data_mem_r[wr_ptr_r] <= bus.rd_data_i;
        keep_mem_r[wr_ptr_r] <= infl_last_r ? last_keep_r : {bytes_lp{1'b1}};
        last_mem_r[wr_ptr_r] <= infl_last_r;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, infl_r} - {1'b0, pop_s};
    end
  end

  assign bus.slot_ready_and_o = release_s;
  assign bus.rd_v_o           = rd_v_s;
  assign bus.rd_addr_o        = addr_r;
  assign bus.tx_v_o           = head_v_s;
  assign bus.tx_data_o        = data_mem_r[rd_ptr_r];
  assign bus.tx_keep_o        = keep_mem_r[rd_ptr_r];
  assign bus.tx_last_o        = head_last_s;
endmodule

// File: tb/tb_tx_frame_streamer.sv
// Bench for tx_frame_streamer: 64-bit and 32-bit instances, a frame table and random frames
// checked against a byte-length based model of the expected reads and beats.
module tb_tx_frame_streamer;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cur_seed = 0;
  int   gcyc = 0;
  int   last_beat_g = -1;
  bit   last_sel = 1'b0;

  typedef struct {
    bit         sel;
    int         size;
    int         mode;
    int         abort_at;
    int         exp_beats;
    logic [7:0] exp_last_keep;
    int         exp_last_addr;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  tx_frame_streamer_if #(.data_width_p(64)) b64 ();
  tx_frame_streamer_if #(.data_width_p(32)) b32 ();

  tx_frame_streamer #(.data_width_p(64)) dut64 (.clk_i(clk), .reset_i(reset), .bus(b64));
  tx_frame_streamer #(.data_width_p(32)) dut32 (.clk_i(clk), .reset_i(reset), .bus(b32));

  function automatic logic [63:0] mem_word(input int seed, input int addr);
    logic [63:0] h;
    h = {32'(seed), 32'(addr)} * 64'h9E37_79B9_7F4A_7C15;
    return h ^ {32'(addr), 32'(seed) ^ 32'h5A5A_0000};
  endfunction

  // Buffer memory: data is returned one cycle after each read request.
  always @(posedge clk) begin
    b64.rd_data_i <= b64.rd_v_o ? mem_word(cur_seed, int'(b64.rd_addr_o)) : 64'd0;
    b32.rd_data_i <= b32.rd_v_o ? 32'(mem_word(cur_seed, int'(b32.rd_addr_o))) : 32'd0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit sv, input logic [15:0] sz, input bit rdy);
    b64.slot_v_i       = sv && !sel;
    b64.size_i         = sz;
    b64.tx_ready_and_i = rdy;
    b32.slot_v_i       = sv && sel;
    b32.size_i         = sz;
    b32.tx_ready_and_i = rdy;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'd0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    last_beat_g = -1;
  endtask

  // mode 0: ready always 1, mode 1: ready toggles 1/0, mode 2: random ready.
  task automatic run_frame(input bit sel, input int size, input int mode, input int abort_at,
                           output int nb, output int lk, output int la);
    int bw, len, words, rem, lastk, seed, budget;
    int rd_q[$];
    logic [63:0] dq[$];
    logic [7:0]  kq[$];
    bit          lq[$];
    int first_rd, first_v, first_acc, last_acc, rel_cyc, rel_cnt, acc, issued, lasts;
    bit aborted, prev_stall, rdy, v, l, rv, sr, p_l;
    logic [63:0] d, p_d, exp_d;
    logic [7:0]  k, p_k;
    int ra;
    bw = sel ? 4 : 8;
    len = (size > 2048) ? 2048 : size;
    words = (len + bw - 1) / bw;
    rem = len % bw;
    lastk = (rem == 0) ? ((1 << bw) - 1) : ((1 << rem) - 1);
    seed = $urandom;
    cur_seed = seed;
    budget = 10 * words + 20;
    first_rd = -1; first_v = -1; first_acc = -1; last_acc = -1; rel_cyc = -1;
    rel_cnt = 0; acc = 0; issued = 0; lasts = 0;
    aborted = 1'b0; prev_stall = 1'b0;
    p_d = 64'd0; p_k = 8'd0; p_l = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      gcyc++;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      drive(sel, 1'b1, (c == 0) ? 16'(size) : 16'($urandom), rdy);
      #1;
      v  = sel ? b32.tx_v_o : b64.tx_v_o;
      d  = sel ? 64'(b32.tx_data_o) : b64.tx_data_o;
      k  = sel ? 8'(b32.tx_keep_o) : b64.tx_keep_o;
      l  = sel ? b32.tx_last_o : b64.tx_last_o;
      rv = sel ? b32.rd_v_o : b64.rd_v_o;
      ra = sel ? int'(b32.rd_addr_o) : int'(b64.rd_addr_o);
      sr = sel ? b32.slot_ready_and_o : b64.slot_ready_and_o;
      if (prev_stall) begin
        chk("hold_valid", 64'(v), 64'd1);
        chk("hold_data", d, p_d);
        chk("hold_keep_last", {k, 7'd0, l}, {p_k, 7'd0, p_l});
      end
      prev_stall = v && !rdy;
      p_d = d; p_k = k; p_l = l;
      if (v && first_v < 0) first_v = c;
      if (rv) begin
        if (first_rd < 0) first_rd = c;
        chk("read_credit", 64'((issued - acc - int'(v && rdy)) < 2), 64'd1);
        rd_q.push_back(ra);
        issued++;
      end
      if (v && rdy) begin
        if (first_acc < 0) begin
          first_acc = c;
          if (last_beat_g >= 0 && last_sel == sel) chk("frame_gap", 64'((gcyc - last_beat_g) >= 3), 64'd1);
        end
        dq.push_back(d); kq.push_back(k); lq.push_back(l);
        if (l) lasts++;
        last_acc = c;
        last_beat_g = gcyc;
        acc++;
      end
      if (sr) begin
        rel_cnt++;
        rel_cyc = c;
      end
      if (abort_at > 0 && acc == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (sr) break;
    end
    last_sel = sel;
    for (int i = 0; i < rd_q.size(); i++) chk("read_addr", 64'(rd_q[i]), 64'(i * bw));
    for (int i = 0; i < dq.size(); i++) begin
      exp_d = sel ? {32'd0, 32'(mem_word(seed, i * bw))} : mem_word(seed, i * bw);
      chk("beat_data", dq[i], exp_d);
      chk("beat_keep", 64'(kq[i]), (i == words - 1) ? 64'(lastk) : 64'((1 << bw) - 1));
      chk("beat_last", 64'(lq[i]), 64'(i == words - 1));
    end
    if (words > 0) begin
      chk("first_rd_cycle", 64'(first_rd), 64'd1);
      chk("first_tx_cycle", 64'(first_v), 64'd3);
    end else begin
      chk("no_read", 64'(first_rd), -64'sd1);
      chk("no_beat", 64'(first_v), -64'sd1);
    end
    if (aborted) begin
      chk("abort_beats", 64'(dq.size()), 64'(abort_at));
      pulse_reset();
      #1;
      chk("abort_outputs", sel ? {b32.slot_ready_and_o, b32.rd_v_o, b32.rd_addr_o, b32.tx_v_o, b32.tx_last_o, 4'd0, b32.tx_keep_o}
                               : {b64.slot_ready_and_o, b64.rd_v_o, b64.rd_addr_o, b64.tx_v_o, b64.tx_last_o, b64.tx_keep_o}, 64'd0);
      chk("abort_data", sel ? 64'(b32.tx_data_o) : b64.tx_data_o, 64'd0);
      chk("abort_no_release", 64'(rel_cnt), 64'd0);
      chk("abort_no_last", 64'(lasts), 64'd0);
    end else begin
      chk("release_seen", 64'(rel_cnt), 64'd1);
      if (rel_cnt == 0) begin
        pulse_reset();
      end else begin
        chk("read_count", 64'(rd_q.size()), 64'(words));
        chk("beat_count", 64'(dq.size()), 64'(words));
        chk("release_cycle", 64'(rel_cyc), (words == 0) ? 64'd1 : 64'(last_acc + 1));
        if (mode == 0 && words > 0) chk("no_bubble", 64'(last_acc - first_acc), 64'(words - 1));
      end
    end
    nb = dq.size();
    lk = (kq.size() > 0) ? int'(kq[kq.size() - 1]) : 0;
    la = (rd_q.size() > 0) ? rd_q[rd_q.size() - 1] : -1;
  endtask

  initial begin
    int nb, lk, la;
    tbl[0]  = '{1'b0, 20,   0, 0, 3,   8'h0F, 16};
    tbl[1]  = '{1'b1, 8,    0, 0, 2,   8'h0F, 4};
    tbl[2]  = '{1'b0, 64,   1, 0, 8,   8'hFF, 56};
    tbl[3]  = '{1'b0, 0,    0, 0, 0,   8'h00, -1};
    tbl[4]  = '{1'b0, 3000, 0, 0, 256, 8'hFF, 2040};
    tbl[5]  = '{1'b0, 80,   0, 2, 2,   8'hFF, -1};
    tbl[6]  = '{1'b0, 20,   0, 0, 3,   8'h0F, 16};
    tbl[7]  = '{1'b1, 3000, 2, 0, 512, 8'h0F, 2044};
    tbl[8]  = '{1'b0, 1,    2, 0, 1,   8'h01, 0};
    tbl[9]  = '{1'b1, 7,    1, 0, 2,   8'h07, 4};
    tbl[10] = '{1'b0, 2049, 0, 0, 256, 8'hFF, 2040};
    tbl[11] = '{1'b0, 15,   2, 0, 2,   8'h7F, 8};
    tbl[12] = '{1'b1, 0,    0, 0, 0,   8'h00, -1};

    drive(1'b0, 1'b0, 16'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("reset_outputs64", {b64.slot_ready_and_o, b64.rd_v_o, b64.rd_addr_o, b64.tx_v_o, b64.tx_last_o, b64.tx_keep_o}, 64'd0);
    chk("reset_data64", b64.tx_data_o, 64'd0);
    chk("reset_outputs32", {b32.slot_ready_and_o, b32.rd_v_o, b32.rd_addr_o, b32.tx_v_o, b32.tx_last_o, b32.tx_keep_o}, 64'd0);
    chk("reset_data32", 64'(b32.tx_data_o), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_frame(tbl[i].sel, tbl[i].size, tbl[i].mode, tbl[i].abort_at, nb, lk, la);
      chk("tbl_beats", 64'(nb), 64'(tbl[i].exp_beats));
      if (tbl[i].abort_at == 0) begin
        chk("tbl_last_keep", 64'(lk), 64'(tbl[i].exp_last_keep));
        chk("tbl_last_addr", 64'(la), 64'(tbl[i].exp_last_addr));
      end
    end

    for (int i = 0; i < 20; i++) begin
      run_frame(1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(2000, 4000)) : int'($urandom_range(0, 120)),
                int'($urandom_range(0, 2)), 0, nb, lk, la);
    end

    drive(1'b0, 1'b0, 16'd0, 1'b1);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tx_frame_streamer.md
TX_FRAME_STREAMER -- requirements
Module: tx_frame_streamer

Interface
REQ-001 Parameter data_width_p, default 64, meaning memory word and stream width in bits; legal values 32 and 64.
REQ-002 Derived bytes_lp = data_width_p/8; addr_width_lp = 11 (2048-byte slot); size_width_lp = 16.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 slot_v_i  input  1  a filled TX slot is available from the buffer memory.
REQ-006 slot_ready_and_o  output  1  one-cycle pulse that dequeues the current slot.
REQ-007 size_i  input  16  frame length in bytes; valid while slot_v_i=1.
REQ-008 rd_v_o  output  1  buffer read request.
REQ-009 rd_addr_o  output  11  byte address; always word-aligned (low log2(bytes_lp) bits = 0).
REQ-010 rd_data_i  input  data_width_p  read data; valid exactly one cycle after rd_v_o.
REQ-011 tx_v_o  output  1  stream beat valid.
REQ-012 tx_ready_and_i  input  1  MAC accepts the beat when tx_v_o & tx_ready_and_i.
REQ-013 tx_data_o  output  data_width_p  beat data; byte 0 in bits [7:0].
REQ-014 tx_keep_o  output  bytes_lp  per-byte valid mask; contiguous from bit 0.
REQ-015 tx_last_o  output  1  marks the final beat of the frame.

Function
REQ-016 FSM states: IDLE, STREAM, DRAIN, RELEASE.
REQ-017 IDLE: when slot_v_i=1, latch len = min(size_i, 2048), set read address 0; go to STREAM if len>0, else to RELEASE.
REQ-018 Word count = ceil(len/bytes_lp); each word is read exactly once, addresses 0, bytes_lp, 2*bytes_lp, ... ascending.
REQ-019 Read data is captured into a 2-entry output FIFO; tx_data_o/tx_keep_o/tx_last_o/tx_v_o come from the FIFO head register (no combinational path from rd_data_i to outputs).
REQ-020 STREAM: rd_v_o=1 only when FIFO occupancy plus reads in flight is less than 2; after the last word is issued, go to DRAIN.
REQ-021 Each FIFO entry carries its data, keep and last; keep = all ones except on the last word, where keep = (1<<(len mod bytes_lp))-1, or all ones if the remainder is 0.
REQ-022 DRAIN: when the last beat is accepted (tx_v_o & tx_ready_and_i & tx_last_o), go to RELEASE.
REQ-023 RELEASE: slot_ready_and_o=1 for exactly one cycle, then go to IDLE; slot_ready_and_o is 0 in every other state.
REQ-024 Latency: with slot_v_i first seen in IDLE at cycle 0 and tx_ready_and_i=1, the first rd_v_o is at cycle 1 and the first tx_v_o is at cycle 3.
REQ-025 Throughput: with tx_ready_and_i held at 1, there is one beat per cycle with no bubbles inside a frame.
REQ-026 Backpressure: while tx_v_o=1 and tx_ready_and_i=0, tx_data_o/tx_keep_o/tx_last_o hold stable; there is no loss or duplication, and at most 2 words are buffered.
REQ-027 A FIFO push and pop in the same cycle are legal and leave the occupancy unchanged.
REQ-028 slot_v_i and size_i are sampled only in IDLE; changes in other states are ignored.
REQ-029 A new slot is not started until RELEASE completes; back-to-back frames have at least 2 idle beat cycles between the last beat and the next first beat.
REQ-030 len = 0: no rd_v_o and no tx beats; slot_ready_and_o pulses at cycle 1.
REQ-031 size_i > 2048 is clamped to 2048 (256 words at 64 b, 512 words at 32 b).

Reset
REQ-032 While reset_i=1 at a clock edge: FSM goes to IDLE, FIFO is emptied, in-flight read is discarded, and counters are cleared.
REQ-033 Reset values: slot_ready_and_o=0, rd_v_o=0, rd_addr_o=0, tx_v_o=0, tx_last_o=0, tx_keep_o=0, tx_data_o=0.
REQ-034 Reset mid-frame: no slot_ready_and_o pulse is produced, and the partial frame is abandoned without a tx_last_o beat.

Verification
REQ-035 64 b, size_i=20, ready=1 -> reads at addresses 0, 8, 16; 3 beats with keep FF, FF, 0F; last on beat 3; one slot_ready_and_o pulse.
REQ-036 32 b, size_i=8 -> 2 beats with keep F, F, last on beat 2; first tx_v_o at cycle 3 after slot_v_i.
REQ-037 64 b, size_i=64, tx_ready_and_i toggling 1/0 every cycle -> 8 beats in order with data matching memory; no rd_v_o while the FIFO plus in-flight count is 2.
REQ-038 size_i=0 -> no rd_v_o and no tx_v_o; slot_ready_and_o pulse at cycle 1.
REQ-039 size_i=3000, 64 b -> exactly 256 beats, last keep FF, last address 2040.
REQ-040 reset_i asserted at beat 2 of a 10-beat frame -> all outputs 0 on the next cycle, no release pulse; the next frame streams correctly from address 0.
